// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage: widths, instruction field positions
// and the fetch controller state encoding.
package inst_fetch_pkg;

  localparam int ROM_AW = 6;
  localparam int INST_W = 32;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNC_MSB  = 25;
  localparam int FUNC_LSB  = 20;
  localparam int SHAMT_MSB = 19;
  localparam int SHAMT_LSB = 15;
  localparam int RD_MSB    = 14;
  localparam int RD_LSB    = 10;
  localparam int RS_MSB    = 9;
  localparam int RS_LSB    = 5;
  localparam int RT_MSB    = 4;
  localparam int RT_LSB    = 0;
  localparam int IMM_MSB   = 25;
  localparam int IMM_LSB   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_field_decode.sv
// Pure combinational slicing of an instruction word into its fields.
module inst_field_decode
  import inst_fetch_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [4:0]        shamt,
  output logic [4:0]        rd,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [15:0]       imm,
  output logic [31:0]       imm_sext
);

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic signed [31:0] imm_sext_s;

  assign op         = inst[OP_MSB:OP_LSB];
  assign func       = inst[FUNC_MSB:FUNC_LSB];
  assign shamt      = inst[SHAMT_MSB:SHAMT_LSB];
  assign rd         = inst[RD_MSB:RD_LSB];
  assign rs         = inst[RS_MSB:RS_LSB];
  assign rt         = inst[RT_MSB:RT_LSB];
  assign imm        = inst[IMM_MSB:IMM_LSB];
  assign imm_sext_s = sext16(inst[IMM_MSB:IMM_LSB]);
  assign imm_sext   = imm_sext_s;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// holds the returned word in an output register under a valid/ready handshake.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int AW        = ROM_AW,
  parameter int WRAP_HALT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW-1:0]     rom_a,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect,
  input  logic [AW-1:0]     redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [AW-1:0]     out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [5:0]        out_op,
  output logic [5:0]        out_func,
  output logic [4:0]        out_shamt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [15:0]       out_imm,
  output logic [31:0]       out_imm_sext,
  output logic              halted
);

  fetch_state_t        state, state_nxt;
  logic [AW-1:0]       pc_p0;
  logic [AW-1:0]       pc_p1;
  logic [INST_W-1:0]   inst_p1;
  logic                vld_p1;
  logic                fire;
  logic                pc_last;

  // A redirect always suppresses the fetch; otherwise fetch when the slot is free
  assign fire    = (state == ST_RUN) && !redirect && (!vld_p1 || out_ready);
  assign pc_last = (pc_p0 == {AW{1'b1}});
  assign rom_a   = pc_p0;

  // Stage p0 -> p1: state, PC and output register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc_p0   <= '0;
      pc_p1   <= '0;
      inst_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: begin
          if (redirect) pc_p0 <= redirect_pc;
        end
        ST_RUN: begin
          if (redirect) begin
            pc_p0  <= redirect_pc;
            vld_p1 <= 1'b0;
          end else if (fire) begin
            inst_p1 <= rom_inst;
            pc_p1   <= pc_p0;
            vld_p1  <= 1'b1;
            pc_p0   <= pc_p0 + AW'(1);
          end
        end
        ST_HALT: begin
          if (redirect) begin
            pc_p0  <= redirect_pc;
            vld_p1 <= 1'b0;
          end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state selection for the fetch controller
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (fire && pc_last && (WRAP_HALT != 0)) state_nxt = ST_HALT;
      ST_HALT: if (redirect) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Controller status output
  always_comb begin
    halted = (state == ST_HALT);
  end

  assign out_valid = vld_p1;
  assign out_pc    = pc_p1;
  assign out_inst  = inst_p1;

  inst_field_decode u_decode (
    .inst     (inst_p1),
    .op       (out_op),
    .func     (out_func),
    .shamt    (out_shamt),
    .rd       (out_rd),
    .rs       (out_rs),
    .rt       (out_rt),
    .imm      (out_imm),
    .imm_sext (out_imm_sext)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural 64-word ROM.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  rom_a;
  logic [31:0] rom_inst;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [5:0]  out_pc;
  logic [31:0] out_inst;
  logic [5:0]  out_op;
  logic [5:0]  out_func;
  logic [4:0]  out_shamt;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [15:0] out_imm;
  logic [31:0] out_imm_sext;
  logic        halted;

  logic [31:0] rom [64];
  int          n_chk = 0;
  int          n_err = 0;

  assign rom_inst = rom[rom_a];

  always #5 clk = ~clk;

  inst_fetch #(.AW(6), .WRAP_HALT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rom_a        (rom_a),
    .rom_inst     (rom_inst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_op       (out_op),
    .out_func     (out_func),
    .out_shamt    (out_shamt),
    .out_rd       (out_rd),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_imm      (out_imm),
    .out_imm_sext (out_imm_sext),
    .halted       (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[1] = 32'h0010_0443;
    rom[4] = 32'h1400_2828;
    rom[5] = 32'h37FF_EA81;

    rst = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_rom_a", 32'(rom_a), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_sext", out_imm_sext, 32'd0);

    // Idle: no fetch without start
    out_ready = 1'b1;
    step();
    check("idle_valid", 32'(out_valid), 32'd0);

    start = 1'b1;
    step();                       // IDLE -> RUN, nothing fetched yet
    start = 1'b0;
    check("start_nofetch", 32'(out_valid), 32'd0);
    step();
    check("pc0_valid", 32'(out_valid), 32'd1);
    check("pc0_pc", 32'(out_pc), 32'd0);
    check("pc0_inst", out_inst, rom[0]);
    step();
    check("pc1_pc", 32'(out_pc), 32'd1);
    check("pc1_inst", out_inst, 32'h0010_0443);
    check("pc1_op", 32'(out_op), 32'd0);
    check("pc1_func", 32'(out_func), 32'd1);
    check("pc1_shamt", 32'(out_shamt), 32'd0);
    check("pc1_rd", 32'(out_rd), 32'd1);
    check("pc1_rs", 32'(out_rs), 32'd2);
    check("pc1_rt", 32'(out_rt), 32'd3);
    step();
    check("pc2_pc", 32'(out_pc), 32'd2);

    // Stall three cycles with word 2 held
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_pc", 32'(out_pc), 32'd2);
      check("stall_inst", out_inst, rom[2]);
      check("stall_rom_a", 32'(rom_a), 32'd3);
    end
    out_ready = 1'b1;
    step();
    check("release_pc", 32'(out_pc), 32'd3);
    check("release_inst", out_inst, rom[3]);
    step();
    check("pc4_pc", 32'(out_pc), 32'd4);
    check("pc4_op", 32'(out_op), 32'd5);
    check("pc4_rs", 32'(out_rs), 32'd1);
    check("pc4_rt", 32'(out_rt), 32'd8);
    check("pc4_imm", 32'(out_imm), 32'h0000_000A);
    check("pc4_sext", out_imm_sext, 32'h0000_000A);
    step();
    check("pc5_pc", 32'(out_pc), 32'd5);
    check("pc5_op", 32'(out_op), 32'h0D);
    check("pc5_imm", 32'(out_imm), 32'h0000_FFFA);
    check("pc5_sext", out_imm_sext, 32'hFFFF_FFFA);

    // Redirect while a word is valid and being accepted
    redirect = 1'b1; redirect_pc = 6'h05;
    step();
    redirect = 1'b0;
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_rom_a", 32'(rom_a), 32'd5);
    step();
    check("redir_pc", 32'(out_pc), 32'd5);
    check("redir_inst", out_inst, rom[5]);

    // Run through to address 63, one word per cycle
    for (int e = 6; e < 64; e++) begin
      step();
      check("seq_pc", 32'(out_pc), 32'(e));
    end
    check("wrap_inst", out_inst, rom[63]);
    check("wrap_halted", 32'(halted), 32'd1);
    check("wrap_rom_a", 32'(rom_a), 32'd0);
    step();                       // word 63 accepted
    check("halt_drain", 32'(out_valid), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("halt_nofetch", 32'(out_valid), 32'd0);
    check("halt_hold", 32'(halted), 32'd1);

    // Restart from HALT by redirect
    redirect = 1'b1; redirect_pc = 6'h10;
    step();
    redirect = 1'b0;
    check("restart_halted", 32'(halted), 32'd0);
    check("restart_rom_a", 32'(rom_a), 32'h10);
    step();
    check("restart_pc", 32'(out_pc), 32'h10);
    check("restart_inst", out_inst, rom[16]);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    step();
    check("stall2_pc", 32'(out_pc), 32'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_rom_a", 32'(rom_a), 32'd0);
    check("rst2_inst", out_inst, 32'd0);
    check("rst2_op", 32'(out_op), 32'd0);
    check("rst2_sext", out_imm_sext, 32'd0);
    out_ready = 1'b1;
    step(); step();
    check("rst2_nofetch", 32'(out_valid), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rst2_restart_pc", 32'(out_pc), 32'd0);
    check("rst2_restart_valid", 32'(out_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
